// File: rtl/systolic_feeder.sv
// Operand feeder for a GRID_SIZE x GRID_SIZE systolic array: lane buffers loaded
// in IDLE, then streamed out with a diagonal skew and a zero drain tail.
module systolic_feeder #(
  parameter int NUM_SIZE  = 16,
  parameter int GRID_SIZE = 2,
  parameter int DEPTH     = 8,
  parameter int ADDR_LEN  = 3,
  localparam int LANE_W   = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1,
  localparam int BUS_W    = NUM_SIZE * GRID_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                wr_sel,
  input  logic [LANE_W-1:0]   wr_lane,
  input  logic [ADDR_LEN-1:0] wr_addr,
  input  logic [NUM_SIZE-1:0] wr_data,
  input  logic                start,
  input  logic [ADDR_LEN:0]   k_len,
  output logic                busy,
  output logic                done,
  output logic                ce,
  output logic [BUS_W-1:0]    north_input,
  output logic [BUS_W-1:0]    west_input
);

  // state  | meaning
  // IDLE   | buffers writable, waiting for start
  // STREAM | ce high, one skewed column of operands per cycle
  // FIN    | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

  localparam int STEP_W = ADDR_LEN + 2;
  localparam int KW     = ADDR_LEN + 1;
  localparam int SKEW   = 2 * (GRID_SIZE - 1);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [KW-1:0]       k_q, k_d;
  logic                ce_q, ce_d;
  logic [BUS_W-1:0]    north_q, north_d;
  logic [BUS_W-1:0]    west_q, west_d;

  logic [NUM_SIZE-1:0] north_mem_q [GRID_SIZE][DEPTH];
  logic [NUM_SIZE-1:0] west_mem_q  [GRID_SIZE][DEPTH];

  logic                wr_en;
  logic [KW-1:0]       k_eff;
  logic [STEP_W-1:0]   last_step;
  logic                load;
  logic [STEP_W-1:0]   rd_step;
  logic [KW-1:0]       rd_k;
  logic [STEP_W-1:0]   diff;
  logic [ADDR_LEN-1:0] rd_addr;

  assign wr_ready  = (state_q == IDLE);
  assign wr_en     = wr_valid && wr_ready && (int'(wr_lane) < GRID_SIZE);
  assign k_eff     = (k_len > KW'(DEPTH)) ? KW'(DEPTH) : k_len;
  assign last_step = {1'b0, k_q} + STEP_W'(SKEW - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < GRID_SIZE; i++) begin
        for (int a = 0; a < DEPTH; a++) begin
          north_mem_q[i][a] <= '0;
          west_mem_q[i][a]  <= '0;
        end
      end
    end else if (wr_en) begin
      if (wr_sel) west_mem_q[wr_lane][wr_addr]  <= wr_data;
      else        north_mem_q[wr_lane][wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    k_d     = k_q;
    ce_d    = 1'b0;
    north_d = '0;
    west_d  = '0;
    load    = 1'b0;
    rd_step = '0;
    rd_k    = k_q;
    diff    = '0;
    rd_addr = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          k_d    = k_eff;
          step_d = '0;
          if (k_eff == '0) begin
            state_d = FIN;
          end else begin
            state_d = STREAM;
            ce_d    = 1'b1;
            load    = 1'b1;
            rd_k    = k_eff;
          end
        end
      end
      STREAM: begin
        if (step_q == last_step) begin
          state_d = FIN;
          step_d  = '0;
        end else begin
          step_d  = step_q + 1'b1;
          ce_d    = 1'b1;
          load    = 1'b1;
          rd_step = step_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Output registers are loaded one cycle ahead; a write landing on the same
    // edge as start is forwarded so the first column sees the new entry.
    if (load) begin
      for (int i = 0; i < GRID_SIZE; i++) begin
        diff = rd_step - STEP_W'(i);
        if ((rd_step >= STEP_W'(i)) && (diff < {1'b0, rd_k})) begin
          rd_addr = diff[ADDR_LEN-1:0];
          if (wr_en && !wr_sel && (int'(wr_lane) == i) && (wr_addr == rd_addr))
            north_d[i*NUM_SIZE +: NUM_SIZE] = wr_data;
          else
            north_d[i*NUM_SIZE +: NUM_SIZE] = north_mem_q[i][rd_addr];
          if (wr_en && wr_sel && (int'(wr_lane) == i) && (wr_addr == rd_addr))
            west_d[i*NUM_SIZE +: NUM_SIZE] = wr_data;
          else
            west_d[i*NUM_SIZE +: NUM_SIZE] = west_mem_q[i][rd_addr];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      k_q     <= '0;
      ce_q    <= 1'b0;
      north_q <= '0;
      west_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      k_q     <= k_d;
      ce_q    <= ce_d;
      north_q <= north_d;
      west_q  <= west_d;
    end
  end

  assign ce          = ce_q;
  assign north_input = north_q;
  assign west_input  = west_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: loads lane buffers, captures each stream
// cycle by cycle and compares against hand values and a small buffer model.
module tb_systolic_feeder;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_sel;
  logic [0:0]  wr_lane;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic [3:0]  k_len;
  logic        busy;
  logic        done;
  logic        ce;
  logic [31:0] north_input;
  logic [31:0] west_input;

  systolic_feeder #(.NUM_SIZE(16), .GRID_SIZE(2), .DEPTH(8), .ADDR_LEN(3)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_lane(wr_lane),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .k_len(k_len),
    .busy(busy), .done(done), .ce(ce),
    .north_input(north_input), .west_input(west_input)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] mn [2][8];
  logic [15:0] mw [2][8];

  logic        cap_ce   [64];
  logic        cap_busy [64];
  logic [31:0] cap_n    [64];
  logic [31:0] cap_w    [64];
  int          cap_len;
  int          done_at;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int lane, input int addr, input logic [15:0] data);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_lane  = 1'(lane);
    wr_addr  = 3'(addr);
    wr_data  = data;
    if (sel) mw[lane][addr] = data;
    else     mn[lane][addr] = data;
    tick();
    wr_valid = 1'b0;
  endtask

  function automatic logic [31:0] exp_bus(input bit sel, input int n, input int k);
    logic [31:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      idx = n - i;
      if (idx >= 0 && idx < k) r[i*16 +: 16] = sel ? mw[i][idx] : mn[i][idx];
    end
    return r;
  endfunction

  // Drives start (plus whatever write the caller set up), then records every
  // cycle up to and including done. inj >= 0 pokes start+write at that cycle.
  task automatic run_stream(input int k, input int inj);
    start = 1'b1;
    k_len = 4'(k);
    tick();
    start    = 1'b0;
    wr_valid = 1'b0;
    done_at  = -1;
    cap_len  = 0;
    for (int c = 0; c < 40; c++) begin
      cap_ce[c]   = ce;
      cap_busy[c] = busy;
      cap_n[c]    = north_input;
      cap_w[c]    = west_input;
      cap_len     = c + 1;
      if (done) begin
        done_at = c;
        break;
      end
      if (c == inj) begin
        start    = 1'b1;
        k_len    = 4'd3;
        wr_valid = 1'b1;
        wr_sel   = 1'b0;
        wr_lane  = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 16'hDEAD;
        chk("wr_ready_in_stream", wr_ready, 1'b0);
      end
      tick();
      start    = 1'b0;
      wr_valid = 1'b0;
    end
    chk("done_seen", done_at >= 0, 1'b1);
    tick();
  endtask

  task automatic check_stream(input string tag, input int k);
    int keff;
    int t;
    keff = (k > 8) ? 8 : k;
    t    = (keff == 0) ? 0 : keff + 2;
    chk({tag, "_done_at"}, 64'(done_at), 64'(t));
    for (int c = 0; c < cap_len; c++) begin
      chk($sformatf("%s_ce_%0d", tag, c), cap_ce[c], (c < t) ? 1'b1 : 1'b0);
      chk($sformatf("%s_busy_%0d", tag, c), cap_busy[c], 1'b1);
      chk($sformatf("%s_north_%0d", tag, c), cap_n[c], exp_bus(1'b0, c, keff));
      chk($sformatf("%s_west_%0d", tag, c), cap_w[c], exp_bus(1'b1, c, keff));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] en [4];
    logic [31:0] ew [4];
    int ce_cnt;

    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 8; a++) begin
        mn[i][a] = '0;
        mw[i][a] = '0;
      end
    rst = 1'b1; wr_valid = 1'b0; wr_sel = 1'b0; wr_lane = '0; wr_addr = '0;
    wr_data = '0; start = 1'b0; k_len = '0;
    tick();
    tick();
    chk("rst_ce", ce, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_north", north_input, 32'h0);
    chk("rst_west", west_input, 32'h0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    rst = 1'b0;
    tick();

    // 2x2 worked example with hand-derived skewed columns
    wr(0, 0, 0, 16'd1); wr(0, 0, 1, 16'd2); wr(0, 1, 0, 16'd3); wr(0, 1, 1, 16'd4);
    wr(1, 0, 0, 16'd5); wr(1, 0, 1, 16'd6); wr(1, 1, 0, 16'd7); wr(1, 1, 1, 16'd8);
    run_stream(2, -1);
    en = '{32'h0000_0001, 32'h0003_0002, 32'h0004_0000, 32'h0000_0000};
    ew = '{32'h0000_0005, 32'h0007_0006, 32'h0008_0000, 32'h0000_0000};
    chk("basic_done_at", 64'(done_at), 64'd4);
    ce_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("basic_hand_north_%0d", c), cap_n[c], en[c]);
      chk($sformatf("basic_hand_west_%0d", c), cap_w[c], ew[c]);
      if (cap_ce[c]) ce_cnt++;
    end
    chk("basic_ce_count", 64'(ce_cnt), 64'd4);
    check_stream("basic", 2);

    // K = 0: straight to FIN
    run_stream(0, -1);
    chk("k0_done_at", 64'(done_at), 64'd0);
    chk("k0_ce", cap_ce[0], 1'b0);
    chk("k0_busy", cap_busy[0], 1'b1);
    chk("k0_busy_after", busy, 1'b0);

    // k_len clamped to DEPTH
    for (int a = 0; a < 8; a++) begin
      wr(0, 0, a, 16'h0100 + 16'(a));
      wr(1, 0, a, 16'h0200 + 16'(a));
      wr(0, 1, a, 16'h0300 + 16'(a));
      wr(1, 1, a, 16'h0400 + 16'(a));
    end
    run_stream(15, -1);
    check_stream("clamp", 15);
    chk("clamp_lane0_last", cap_n[7], 32'h0306_0107);
    chk("clamp_lane0_drain", cap_n[8], 32'h0307_0000);

    // start and write pokes during STREAM are ignored
    run_stream(8, 2);
    check_stream("inject", 8);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("inject_idle_busy_%0d", c), busy, 1'b0);
      chk($sformatf("inject_idle_ce_%0d", c), ce, 1'b0);
      tick();
    end

    // write and start in the same IDLE cycle
    wr_valid = 1'b1; wr_sel = 1'b0; wr_lane = 1'b0; wr_addr = 3'd0; wr_data = 16'h0077;
    mn[0][0] = 16'h0077;
    run_stream(1, -1);
    chk("fwd_first", cap_n[0], 32'h0000_0077);
    check_stream("fwd", 1);

    // back-to-back replay
    run_stream(3, -1);
    check_stream("replay1", 3);
    run_stream(3, -1);
    check_stream("replay2", 3);

    // reset in stream cycle 2
    start = 1'b1; k_len = 4'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort_ce_before", ce, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_ce", ce, 1'b0);
    chk("abort_north", north_input, 32'h0);
    chk("abort_west", west_input, 32'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_wr_ready", wr_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("abort_done_%0d", c), done, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 8; a++) begin
        mn[i][a] = '0;
        mw[i][a] = '0;
      end
    tick();
    run_stream(2, -1);
    chk("readback_north1", cap_n[1], 32'h0);
    check_stream("readback", 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
